decimal_add_sequencer: RTL and testbench

Sequencing controller for the two-digit decimal adder on the keypad board. Takes one-hot keypad digit lines, qualifies each press, captures operand A then operand B as 4-bit binary, and presents the registered 5-bit sum with a valid flag. Sits between the raw keypad inputs and the seven-segment/LED display logic.

---
 rtl/decimal_add_sequencer_pkg.sv | 37 +++
 rtl/decimal_add_sequencer_if.sv | 24 ++
 rtl/decimal_add_sequencer_key_qualifier.sv | 63 ++++++
 rtl/decimal_add_sequencer.sv | 122 ++++++++++++
 tb/tb_decimal_add_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/decimal_add_sequencer_pkg.sv
// Shared types and helpers for the two-digit decimal adder sequencer:
// FSM state encoding, operand/sum widths and the keypad one-hot encoder.
package dec_add_pkg;

    localparam int DIGIT_W = 4;
    localparam int SUM_W   = 5;
    localparam int KEY_W   = 10;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SHOW   = 2'd2
    } state_e;

    typedef struct packed {
        logic               legal;
        logic [DIGIT_W-1:0] code;
    } enc_t;

    // Legal only when exactly one key line is high; code is that line's index.
    function automatic enc_t encode_key(input logic [KEY_W-1:0] k);
        enc_t r;
        int   n;
        r.legal = 1'b0;
        r.code  = '0;
        n       = 0;
        for (int i = 0; i < KEY_W; i++) begin
            if (k[i]) begin
                n++;
                r.code = DIGIT_W'(i);
            end
        end
        r.legal = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/decimal_add_sequencer_if.sv
// Keypad-side inputs and display-side outputs of the decimal adder sequencer.
interface decimal_add_sequencer_if;
    import dec_add_pkg::*;

    logic [KEY_W-1:0]   key;
    logic               clr;
    logic [DIGIT_W-1:0] digit_a;
    logic [DIGIT_W-1:0] digit_b;
    logic [SUM_W-1:0]   sum;
    logic               sum_valid;
    logic [1:0]         state_o;
    logic               err;

    modport master (
        output key, clr,
        input  digit_a, digit_b, sum, sum_valid, state_o, err
    );

    modport slave (
        input  key, clr,
        output digit_a, digit_b, sum, sum_valid, state_o, err
    );

endinterface

// File: rtl/decimal_add_sequencer_key_qualifier.sv
// Keypad debouncer: registers the raw lines, requires a stable pattern for
// DEBOUNCE_CYCLES samples, and emits one accept strobe per physical press.
module key_qualifier
    import dec_add_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   key_i,
    output logic               accept_o,
    output logic [DIGIT_W-1:0] code_o,
    output logic               illegal_o
);

    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

    logic [KEY_W-1:0] key_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             stable;
    enc_t             enc;

    assign stable = (cnt_q == DB);

    // A freshly changed sample counts as the first stable one.
    always_comb begin
        cnt_d = cnt_q;
        if (key_i != key_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q != DB) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign accept_o = !held_q && stable && (key_q != '0);

    always_comb begin
        held_d = held_q;
        if (accept_o) begin
            held_d = 1'b1;
        end else if (held_q && stable && (key_q == '0)) begin
            held_d = 1'b0;
        end
    end

    assign enc       = encode_key(key_q);
    assign code_o    = enc.code;
    assign illegal_o = !enc.legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            cnt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            key_q  <= key_i;
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end

endmodule

// File: rtl/decimal_add_sequencer.sv
// Two-digit decimal adder sequencer: captures operand A then B from qualified
// keypad presses and presents their registered sum. Optional macro
// DEC_ADD_ERR_EN enables the err pulse on multi-hot key patterns.
module decimal_add_sequencer
    import dec_add_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decimal_add_sequencer_if.slave   bus
);

    logic               accept;
    logic [DIGIT_W-1:0] code;
    logic               illegal;
    logic               take;

    state_e             state_q, state_d;
    logic [DIGIT_W-1:0] digit_a_q, digit_a_d;
    logic [DIGIT_W-1:0] digit_b_q, digit_b_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               sum_valid_q, sum_valid_d;

    key_qualifier #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_qual (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_i     (bus.key),
        .accept_o  (accept),
        .code_o    (code),
        .illegal_o (illegal)
    );

    assign take = accept && !illegal;

    // clr overrides and discards any accept arriving on the same edge.
    always_comb begin
        state_d     = state_q;
        digit_a_d   = digit_a_q;
        digit_b_d   = digit_b_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        if (bus.clr) begin
            state_d     = WAIT_A;
            digit_a_d   = '0;
            digit_b_d   = '0;
            sum_d       = '0;
            sum_valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (take) begin
                        digit_a_d = code;
                        digit_b_d = '0;
                        state_d   = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (take) begin
                        digit_b_d   = code;
                        sum_d       = {1'b0, digit_a_q} + {1'b0, code};
                        sum_valid_d = 1'b1;
                        state_d     = SHOW;
                    end
                end
                SHOW: begin
                    if (take) begin
                        digit_a_d   = code;
                        digit_b_d   = '0;
                        sum_d       = '0;
                        sum_valid_d = 1'b0;
                        state_d     = WAIT_B;
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_A;
            digit_a_q   <= '0;
            digit_b_q   <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_a_q   <= digit_a_d;
            digit_b_q   <= digit_b_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

`ifdef DEC_ADD_ERR_EN
    logic err_q, err_d;

    assign err_d = accept && illegal && !bus.clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.digit_a   = digit_a_q;
    assign bus.digit_b   = digit_b_q;
    assign bus.sum       = sum_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_decimal_add_sequencer.sv
// Bench for decimal_add_sequencer: directed scenarios plus random keypad
// activity, compared every cycle against a sample-history reference model.
module tb_decimal_add_sequencer;
    import dec_add_pkg::*;

    localparam int DB = 4;
`ifdef DEC_ADD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decimal_add_sequencer_if bus_if ();

    decimal_add_sequencer #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: raw samples since reset plus the behavioural outputs.
    logic [9:0] hist[$];
    bit         released;
    int         m_a, m_b, m_sum, m_state;
    bit         m_valid, m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (%s): got %0d expected %0d", tag, phase, obs, exp);
        end
    endtask

    function automatic int run_len();
        int n;
        n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1]) break;
            n++;
            if (n >= DB) break;
        end
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        released = 1'b1;
        m_a = 0; m_b = 0; m_sum = 0; m_state = 0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [9:0] k, input bit c);
        int         run, code, ones;
        logic [9:0] s;
        bit         press, rel;
        run   = run_len();
        s     = (hist.size() != 0) ? hist[hist.size()-1] : 10'd0;
        press = released && (run >= DB) && (s != 10'd0);
        rel   = !released && (run >= DB) && (s == 10'd0);
        ones  = $countones(s);
        code  = 0;
        for (int i = 0; i < 10; i++) if (s[i]) code = i;
        m_err = 1'b0;
        if (press) released = 1'b0;
        if (rel)   released = 1'b1;
        if (c) begin
            m_a = 0; m_b = 0; m_sum = 0; m_valid = 1'b0; m_state = 0;
        end else if (press && ones == 1) begin
            if (m_state == 0) begin
                m_a = code; m_b = 0; m_state = 1;
            end else if (m_state == 1) begin
                m_b = code; m_sum = m_a + code; m_valid = 1'b1; m_state = 2;
            end else begin
                m_a = code; m_b = 0; m_sum = 0; m_valid = 1'b0; m_state = 1;
            end
        end else if (press) begin
            m_err = ERR_EN;
        end
        hist.push_back(k);
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic check_all();
        check("digit_a",   32'(bus_if.digit_a),   32'(m_a));
        check("digit_b",   32'(bus_if.digit_b),   32'(m_b));
        check("sum",       32'(bus_if.sum),       32'(m_sum));
        check("sum_valid", 32'(bus_if.sum_valid), 32'(m_valid));
        check("state_o",   32'(bus_if.state_o),   32'(m_state));
        check("err",       32'(bus_if.err),       32'(m_err));
    endtask

    task automatic cyc(input logic [9:0] k, input bit c);
        bus_if.key = k;
        bus_if.clr = c;
        model_edge(k, c);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic [9:0] k, input int n);
        for (int i = 0; i < n; i++) cyc(k, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog (%s): got timeout expected finish", phase);
        $fatal(1, "watchdog");
    end

    initial begin
        int errs_seen;
        int seg_len, pick;
        logic [9:0] pat;

        bus_if.key = '0;
        bus_if.clr = 1'b0;
        model_reset();
        @(negedge clk);
        phase = "reset";
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        phase = "press3";
        hold(10'd1 << 3, 4);
        check("lat_before", 32'(bus_if.digit_a), 32'd0);
        cyc(10'd1 << 3, 1'b0);
        check("lat_at", 32'(bus_if.digit_a), 32'd3);
        hold(10'd1 << 3, 1);
        hold(10'd0, 6);
        phase = "press5";
        hold(10'd1 << 5, 6);
        check("sum_3p5", 32'(bus_if.sum), 32'd8);
        check("state_show", 32'(bus_if.state_o), 32'd2);
        hold(10'd0, 6);

        phase = "nine_nine";
        hold(10'd1 << 9, 6); hold(10'd0, 6);
        hold(10'd1 << 9, 6);
        check("sum_18", 32'(bus_if.sum), 32'd18);
        hold(10'd0, 6);
        phase = "new_op";
        hold(10'd1 << 2, 6);
        check("newop_a", 32'(bus_if.digit_a), 32'd2);
        check("newop_valid", 32'(bus_if.sum_valid), 32'd0);
        check("newop_state", 32'(bus_if.state_o), 32'd1);
        hold(10'd0, 6);

        phase = "bounce";
        for (int i = 0; i < 5; i++) begin
            hold(10'd1 << 4, 2);
            hold(10'd0, 2);
        end
        check("bounce_none", 32'(bus_if.state_o), 32'd1);
        hold(10'd1 << 4, 6);
        check("bounce_b", 32'(bus_if.digit_b), 32'd4);
        check("bounce_sum", 32'(bus_if.sum), 32'd6);
        hold(10'd0, 6);

        phase = "multihot";
        errs_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(10'b0000100001, 1'b0);
            if (bus_if.err === 1'b1) errs_seen++;
        end
        check("err_pulses", 32'(errs_seen), ERR_EN ? 32'd1 : 32'd0);
        check("multihot_state", 32'(bus_if.state_o), 32'd2);
        hold(10'd0, 6);

        phase = "clr_vs_accept";
        hold(10'd1 << 1, 6); hold(10'd0, 6);
        hold(10'd1 << 6, 4);
        cyc(10'd1 << 6, 1'b1);
        check("clr_state", 32'(bus_if.state_o), 32'd0);
        check("clr_a", 32'(bus_if.digit_a), 32'd0);
        hold(10'd1 << 6, 6);
        check("clr_nocap", 32'(bus_if.digit_a), 32'd0);
        hold(10'd0, 6);

        phase = "async_reset";
        hold(10'd1 << 8, 6); hold(10'd0, 6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus_if.key = 10'd1 << 7;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold(10'd1 << 7, 6);
        check("reset_held_a", 32'(bus_if.digit_a), 32'd7);
        hold(10'd0, 6);

        phase = "random";
        for (int seg = 0; seg < 300; seg++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4) begin
                pat = '0;
            end else if (pick < 8) begin
                pat = 10'd1 << $urandom_range(0, 9);
            end else if (pick == 8) begin
                pat = (10'd1 << $urandom_range(0, 4)) | (10'd1 << $urandom_range(5, 9));
            end else begin
                pat = 10'($urandom);
            end
            seg_len = $urandom_range(1, 8);
            for (int i = 0; i < seg_len; i++) cyc(pat, ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
